// File: rtl/sci_pkg.sv
// SCI shared definitions: command encodings, FSM state encoding, frame length.
// Latency: n/a (package only).
// Backpressure: n/a. Shared by the initiator (sci_master) and the neuron-side responder.
package sci_pkg;

  // Command bit carried first in every request frame
  localparam logic SCI_CMD_WRITE = 1'b1;
  localparam logic SCI_CMD_READ  = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SEND     = 3'd2,
    WAIT_ACK = 3'd3,
    RECV     = 3'd4,
    DONE     = 3'd5
  } sci_state_e;

  // Number of bits on the REQ line: cmd + address (+ data for writes)
  function automatic int unsigned sci_frame_len(input logic        wnr,
                                                input int unsigned addr_width,
                                                input int unsigned data_width);
    int unsigned len;
    len = 1 + addr_width;
    if (wnr == SCI_CMD_WRITE) len = len + data_width;
    return len;
  endfunction

endpackage

// File: rtl/sci_master_shifter.sv
// SCI frame shifter: PISO for the outgoing request frame, SIPO for read data, shared bit counter.
// Latency: load/shift take effect on the next clock; sdout and rx_word are combinational views.
// Backpressure: none; the owning FSM decides when to load or shift.
// Ports: load/wnr/addr/wdata capture a frame; shift_out advances the PISO; rx_start/rx_shift
//        clock sdin into the SIPO; sdout = next frame bit; cnt_zero/cnt_one report counter state;
//        rx_word = received word including the bit on sdin this cycle. Requires DATA_WIDTH >= 2.
module sci_master_shifter
  import sci_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  wnr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  shift_out,
  input  logic                  rx_start,
  input  logic                  rx_shift,
  input  logic                  sdin,
  output logic                  sdout,
  output logic                  cnt_zero,
  output logic                  cnt_one,
  output logic [DATA_WIDTH-1:0] rx_word
);

  localparam int FRAME_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  logic [FRAME_W-1:0]    tx_q;
  logic [DATA_WIDTH-2:0] rx_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] tx_data;

  // Reads carry no data field; keep the unused tail zero
  assign tx_data  = (wnr == SCI_CMD_WRITE) ? wdata : '0;

  // Frame is left-aligned so the MSB is always the next bit to drive
  assign sdout    = tx_q[FRAME_W-1];
  assign cnt_zero = (cnt_q == '0);
  assign cnt_one  = (cnt_q == CNT_W'(1));
  assign rx_word  = {rx_q, sdin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q  <= '0;
      rx_q  <= '0;
      cnt_q <= '0;
    end else if (load) begin
      tx_q  <= {wnr, addr, tx_data};
      cnt_q <= CNT_W'(sci_frame_len(wnr, ADDR_WIDTH, DATA_WIDTH));
    end else if (shift_out) begin
      tx_q  <= {tx_q[FRAME_W-2:0], 1'b0};
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (rx_start) begin
      // MSB arrives with the ACK; DATA_WIDTH-1 bits remain
      rx_q  <= (DATA_WIDTH-1)'(sdin);
      cnt_q <= CNT_W'(DATA_WIDTH - 1);
    end else if (rx_shift) begin
      rx_q  <= rx_word[DATA_WIDTH-2:0];
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/sci_master.sv
// SCI initiator: turns host read/write requests into bit-serial SCI frames and returns data/status.
// Latency: accept N -> CSN low N+1, frame bits N+2..N+1+L, WAIT_ACK from N+2+L; ACK at M -> RSP_VALID at M+1.
// Backpressure: REQ_READY high only in IDLE; one transaction in flight, next accept the cycle after DONE.
// Ports: CLK/RSTN clock and async active-low reset; REQ_* host request (valid/ready, wnr, sel, addr,
//        wdata); RSP_* one-cycle completion (valid, rdata, error); SCI_CSN one-hot active-low selects,
//        SCI_REQ serial request, SCI_RESP/SCI_ACK shared responder bus. All outputs are registered.
module sci_master
  import sci_pkg::*;
#(
  parameter int NUM_PERIPHERALS = 4,
  parameter int SEL_WIDTH       = 2,
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic                       REQ_WNR,
  input  logic [SEL_WIDTH-1:0]       REQ_SEL,
  input  logic [ADDR_WIDTH-1:0]      REQ_ADDR,
  input  logic [DATA_WIDTH-1:0]      REQ_WDATA,
  output logic                       RSP_VALID,
  output logic [DATA_WIDTH-1:0]      RSP_RDATA,
  output logic                       RSP_ERROR,
  output logic [NUM_PERIPHERALS-1:0] SCI_CSN,
  output logic                       SCI_REQ,
  input  logic                       SCI_RESP,
  input  logic                       SCI_ACK
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [NUM_PERIPHERALS-1:0] CSN_IDLE = '1;

  sci_state_e                 state, state_nxt;
  logic [NUM_PERIPHERALS-1:0] csn_q, csn_nxt;
  logic                       req_q, req_nxt;
  logic                       rdy_q, rdy_nxt;
  logic                       rsp_vld_q, rsp_vld_nxt;
  logic                       rsp_err_q, rsp_err_nxt;
  logic [DATA_WIDTH-1:0]      rsp_rdata_q, rsp_rdata_nxt;
  logic                       wnr_q, wnr_nxt;
  logic [TMR_W-1:0]           tmr_q, tmr_nxt;

  logic                       sel_bad;
  logic                       load, shift_out, rx_start, rx_shift;
  logic                       sdout, cnt_zero, cnt_one;
  logic [DATA_WIDTH-1:0]      rx_word;

  // REQ_SEL may be wider than needed, so out-of-range indices are possible
  assign sel_bad = (32'(REQ_SEL) >= 32'(NUM_PERIPHERALS));

  sci_master_shifter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
    .clk       (CLK),
    .rst_n     (RSTN),
    .load      (load),
    .wnr       (REQ_WNR),
    .addr      (REQ_ADDR),
    .wdata     (REQ_WDATA),
    .shift_out (shift_out),
    .rx_start  (rx_start),
    .rx_shift  (rx_shift),
    .sdin      (SCI_RESP),
    .sdout     (sdout),
    .cnt_zero  (cnt_zero),
    .cnt_one   (cnt_one),
    .rx_word   (rx_word)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state       <= IDLE;
      csn_q       <= CSN_IDLE;
      req_q       <= 1'b0;
      rdy_q       <= 1'b1;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wnr_q       <= 1'b0;
      tmr_q       <= '0;
    end else begin
      state       <= state_nxt;
      csn_q       <= csn_nxt;
      req_q       <= req_nxt;
      rdy_q       <= rdy_nxt;
      rsp_vld_q   <= rsp_vld_nxt;
      rsp_err_q   <= rsp_err_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      wnr_q       <= wnr_nxt;
      tmr_q       <= tmr_nxt;
    end
  end

  // Outputs are computed for the state being entered so every pin comes straight from a flop
  always_comb begin
    state_nxt     = state;
    csn_nxt       = csn_q;
    req_nxt       = 1'b0;
    rsp_err_nxt   = rsp_err_q;
    rsp_rdata_nxt = rsp_rdata_q;
    wnr_nxt       = wnr_q;
    tmr_nxt       = tmr_q;
    load          = 1'b0;
    shift_out     = 1'b0;
    rx_start      = 1'b0;
    rx_shift      = 1'b0;

    case (state)
      IDLE: begin
        if (REQ_VALID && rdy_q) begin
          if (sel_bad) begin
            state_nxt     = DONE;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end else begin
            state_nxt = SETUP;
            load      = 1'b1;
            wnr_nxt   = REQ_WNR;
            csn_nxt   = ~(NUM_PERIPHERALS'(1) << REQ_SEL);
          end
        end
      end

      SETUP: begin
        shift_out = 1'b1;
        req_nxt   = sdout;
        state_nxt = SEND;
      end

      // Counter hits zero while the last frame bit is still on the pin
      SEND: begin
        if (cnt_zero) begin
          state_nxt = WAIT_ACK;
          tmr_nxt   = '0;
        end else begin
          shift_out = 1'b1;
          req_nxt   = sdout;
        end
      end

      // ACK wins over timeout in the final allowed cycle
      WAIT_ACK: begin
        if (SCI_ACK) begin
          if (wnr_q == SCI_CMD_READ) begin
            rx_start  = 1'b1;
            state_nxt = RECV;
          end else begin
            state_nxt     = DONE;
            rsp_err_nxt   = 1'b0;
            rsp_rdata_nxt = '0;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt     = DONE;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
        end else begin
          tmr_nxt = tmr_q + TMR_W'(1);
        end
      end

      // Responder must hold ACK for the whole data burst
      RECV: begin
        if (!SCI_ACK) begin
          state_nxt     = DONE;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
        end else begin
          rx_shift = 1'b1;
          if (cnt_one) begin
            state_nxt     = DONE;
            rsp_err_nxt   = 1'b0;
            rsp_rdata_nxt = rx_word;
          end
        end
      end

      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Chip select releases in the same cycle the response is presented
    if (state_nxt == DONE) csn_nxt = CSN_IDLE;
  end

  assign rdy_nxt     = (state_nxt == IDLE);
  assign rsp_vld_nxt = (state_nxt == DONE);

  assign REQ_READY = rdy_q;
  assign RSP_VALID = rsp_vld_q;
  assign RSP_ERROR = rsp_err_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign SCI_CSN   = csn_q;
  assign SCI_REQ   = req_q;

endmodule

// File: tb/tb_sci_master.sv
// Directed testbench for sci_master with three responders, 4-bit address, 8-bit data, timeout 16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sci_master;

  logic       CLK;
  logic       RSTN;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic       REQ_WNR;
  logic [1:0] REQ_SEL;
  logic [3:0] REQ_ADDR;
  logic [7:0] REQ_WDATA;
  logic       RSP_VALID;
  logic [7:0] RSP_RDATA;
  logic       RSP_ERROR;
  logic [2:0] SCI_CSN;
  logic       SCI_REQ;
  logic       SCI_RESP;
  logic       SCI_ACK;

  int vectors;
  int miscompares;

  sci_master #(
    .NUM_PERIPHERALS (3),
    .SEL_WIDTH       (2),
    .ADDR_WIDTH      (4),
    .DATA_WIDTH      (8),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WNR   (REQ_WNR),
    .REQ_SEL   (REQ_SEL),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_WDATA (REQ_WDATA),
    .RSP_VALID (RSP_VALID),
    .RSP_RDATA (RSP_RDATA),
    .RSP_ERROR (RSP_ERROR),
    .SCI_CSN   (SCI_CSN),
    .SCI_REQ   (SCI_REQ),
    .SCI_RESP  (SCI_RESP),
    .SCI_ACK   (SCI_ACK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request at a falling edge; returns at the falling edge of the SETUP cycle
  task automatic issue(input string pfx, input logic wnr, input logic [1:0] sel,
                       input logic [3:0] addr, input logic [7:0] wdata);
    chk({pfx, "_ready_before"}, REQ_READY, 1'b1);
    REQ_VALID = 1'b1;
    REQ_WNR   = wnr;
    REQ_SEL   = sel;
    REQ_ADDR  = addr;
    REQ_WDATA = wdata;
    tick();
    REQ_VALID = 1'b0;
  endtask

  // Collect len serial bits MSB first, checking the chip select never moves
  task automatic shift_frame(input int len, input logic [2:0] csn_exp,
                             output logic [31:0] bits, output logic ok);
    bits = '0;
    ok   = 1'b1;
    for (int k = 0; k < len; k++) begin
      tick();
      bits = {bits[30:0], SCI_REQ};
      if (SCI_CSN !== csn_exp || RSP_VALID !== 1'b0) ok = 1'b0;
    end
  endtask

  task automatic write_txn(input string pfx, input logic [1:0] sel, input logic [3:0] addr,
                           input logic [7:0] wdata, input logic [2:0] csn_exp,
                           input logic [12:0] frame_exp, input int ack_gap);
    logic [31:0] bits;
    logic        ok;
    issue(pfx, 1'b1, sel, addr, wdata);
    chk({pfx, "_setup_csn"}, SCI_CSN, csn_exp);
    chk({pfx, "_setup_req"}, SCI_REQ, 1'b0);
    shift_frame(13, csn_exp, bits, ok);
    chk({pfx, "_frame"}, bits, frame_exp);
    chk({pfx, "_frame_csn"}, ok, 1'b1);
    ok = 1'b1;
    for (int k = 0; k < ack_gap; k++) begin
      tick();
      if (SCI_REQ !== 1'b0 || SCI_CSN !== csn_exp || RSP_VALID !== 1'b0) ok = 1'b0;
    end
    chk({pfx, "_wait_quiet"}, ok, 1'b1);
    SCI_ACK = 1'b1;
    tick();
    SCI_ACK = 1'b0;
    chk({pfx, "_rsp_valid"}, RSP_VALID, 1'b1);
    chk({pfx, "_rsp_error"}, RSP_ERROR, 1'b0);
    chk({pfx, "_rsp_rdata"}, RSP_RDATA, 8'h00);
    chk({pfx, "_done_csn"}, SCI_CSN, 3'b111);
    chk({pfx, "_done_ready"}, REQ_READY, 1'b0);
    tick();
    chk({pfx, "_pulse_end"}, RSP_VALID, 1'b0);
    chk({pfx, "_ready_after"}, REQ_READY, 1'b1);
  endtask

  // Responder holds ACK for ack_bits cycles from WAIT_ACK entry, then releases it
  task automatic read_txn(input string pfx, input logic [1:0] sel, input logic [3:0] addr,
                          input logic [2:0] csn_exp, input logic [4:0] frame_exp,
                          input logic [7:0] data, input int ack_bits,
                          input logic err_exp, input logic [7:0] rdata_exp);
    logic [31:0] bits;
    logic        ok;
    issue(pfx, 1'b0, sel, addr, 8'hFF);
    chk({pfx, "_setup_csn"}, SCI_CSN, csn_exp);
    shift_frame(5, csn_exp, bits, ok);
    chk({pfx, "_frame"}, bits, frame_exp);
    chk({pfx, "_frame_csn"}, ok, 1'b1);
    tick();
    ok = 1'b1;
    for (int j = 0; j < ack_bits; j++) begin
      if (SCI_REQ !== 1'b0 || SCI_CSN !== csn_exp || RSP_VALID !== 1'b0) ok = 1'b0;
      SCI_ACK  = 1'b1;
      SCI_RESP = data[7-j];
      tick();
    end
    SCI_ACK  = 1'b0;
    SCI_RESP = 1'b0;
    chk({pfx, "_recv_quiet"}, ok, 1'b1);
    if (ack_bits < 8) tick();
    chk({pfx, "_rsp_valid"}, RSP_VALID, 1'b1);
    chk({pfx, "_rsp_error"}, RSP_ERROR, err_exp);
    chk({pfx, "_rsp_rdata"}, RSP_RDATA, rdata_exp);
    chk({pfx, "_done_csn"}, SCI_CSN, 3'b111);
    tick();
    chk({pfx, "_pulse_end"}, RSP_VALID, 1'b0);
    chk({pfx, "_ready_after"}, REQ_READY, 1'b1);
  endtask

  initial begin
    logic [31:0] bits;
    logic        ok;
    int          n;

    vectors     = 0;
    miscompares = 0;
    RSTN        = 1'b0;
    REQ_VALID   = 1'b0;
    REQ_WNR     = 1'b0;
    REQ_SEL     = 2'd0;
    REQ_ADDR    = 4'h0;
    REQ_WDATA   = 8'h00;
    SCI_RESP    = 1'b0;
    SCI_ACK     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_csn", SCI_CSN, 3'b111);
    chk("rst_req", SCI_REQ, 1'b0);
    chk("rst_rsp_valid", RSP_VALID, 1'b0);
    chk("rst_rsp_rdata", RSP_RDATA, 8'h00);
    chk("rst_rsp_error", RSP_ERROR, 1'b0);
    RSTN = 1'b1;
    tick();
    chk("rst_ready", REQ_READY, 1'b1);

    // 1: write sel 2, addr 5, data A3, ACK three cycles after the last bit
    write_txn("t1", 2'd2, 4'h5, 8'hA3, 3'b011, 13'b1_0101_1010_0011, 3);

    // 2: read sel 0, addr C, eight ACK cycles returning 5E
    read_txn("t2", 2'd0, 4'hC, 3'b110, 5'b0_1100, 8'h5E, 8, 1'b0, 8'h5E);

    // 3: write with no ACK; RSP_VALID lands in the 17th cycle counting WAIT_ACK entry as the first
    issue("t3", 1'b1, 2'd1, 4'h3, 8'h0F);
    chk("t3_setup_csn", SCI_CSN, 3'b101);
    shift_frame(13, 3'b101, bits, ok);
    chk("t3_frame", bits, 13'b1_0011_0000_1111);
    chk("t3_frame_csn", ok, 1'b1);
    tick();
    chk("t3_wait_csn", SCI_CSN, 3'b101);
    n = 0;
    while (RSP_VALID !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t3_timeout_cycles", n, 16);
    chk("t3_rsp_error", RSP_ERROR, 1'b1);
    chk("t3_rsp_rdata", RSP_RDATA, 8'h00);
    chk("t3_done_csn", SCI_CSN, 3'b111);
    tick();
    chk("t3_ready_after", REQ_READY, 1'b1);

    // 4: read sel 1, ACK drops after four data bits
    read_txn("t4", 2'd1, 4'h7, 3'b101, 5'b0_0111, 8'hD2, 4, 1'b1, 8'h00);

    // 5: out-of-range select completes with error and no bus activity
    issue("t5", 1'b1, 2'd3, 4'h1, 8'h55);
    chk("t5_rsp_valid", RSP_VALID, 1'b1);
    chk("t5_rsp_error", RSP_ERROR, 1'b1);
    chk("t5_rsp_rdata", RSP_RDATA, 8'h00);
    chk("t5_csn", SCI_CSN, 3'b111);
    chk("t5_req", SCI_REQ, 1'b0);
    chk("t5_ready_done", REQ_READY, 1'b0);
    tick();
    chk("t5_pulse_end", RSP_VALID, 1'b0);
    chk("t5_ready_after", REQ_READY, 1'b1);
    chk("t5_csn_after", SCI_CSN, 3'b111);

    // 6: reset in the middle of SEND aborts silently, then a write completes
    issue("t6a", 1'b1, 2'd0, 4'h9, 8'hFF);
    tick();
    tick();
    tick();
    tick();
    chk("t6_send_csn", SCI_CSN, 3'b110);
    RSTN = 1'b0;
    #1;
    chk("t6_async_csn", SCI_CSN, 3'b111);
    chk("t6_async_req", SCI_REQ, 1'b0);
    chk("t6_async_rsp_valid", RSP_VALID, 1'b0);
    tick();
    RSTN = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (RSP_VALID !== 1'b0 || SCI_CSN !== 3'b111 || SCI_REQ !== 1'b0) ok = 1'b0;
    end
    chk("t6_quiet_after_reset", ok, 1'b1);
    chk("t6_ready_after_reset", REQ_READY, 1'b1);
    write_txn("t6b", 2'd0, 4'hA, 8'h3C, 3'b110, 13'b1_1010_0011_1100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
